// File: rtl/pop_read_sched.sv
// pop_read_sched: schedules population sweeps and round-robin requester reads onto one register-file read port
module pop_read_sched #(
    parameter int POPSIZE    = 100,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 2,
    localparam int AW        = $clog2(POPSIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  new_data,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rsp_vld,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  sweep_vld,
    output logic [AW-1:0]         sweep_idx,
    output logic                  sweep_done,
    output logic [AW-1:0]         rf_read_addr,
    output logic                  rf_rd_rqst,
    input  logic                  rf_data_vld,
    input  logic [DATA_WIDTH-1:0] rf_data,
    output logic                  addr_err,
    output logic                  proto_err
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0] IDLE = 2'd0, SWEEP = 2'd1, DRAIN = 2'd2;
    localparam logic [AW-1:0] LAST_IDX = AW'(POPSIZE - 1);
    localparam logic [AW:0] POP_LIM = (AW + 1)'(POPSIZE);
    localparam logic [IW-1:0] LAST_REQ = IW'(NUM_REQ - 1);
    localparam logic [IW:0] NREQ = (IW + 1)'(NUM_REQ);

    logic [1:0] state, state_nxt;
    logic [AW-1:0] cnt, sel_addr, tag_idx;
    logic [IW-1:0] last, start, off, win, tag_owner, err_owner;
    logic [IW:0] sum;
    logic [2*NUM_REQ-1:0] rot;
    logic pend, hit, grant, bad, sweep_issue, req_issue, req_rsp;
    logic tag_vld, tag_sweep, err_vld;

    // round-robin pick: rotate requests so the search starts one past the last winner
    always_comb begin
        start = (last == LAST_REQ) ? '0 : last + 1'b1;
        rot = {req, req} >> start;
        hit = 1'b0;
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) if (rot[k]) begin hit = 1'b1; off = IW'(k); end
        sum = {1'b0, start} + {1'b0, off};
        win = (sum >= NREQ) ? IW'(sum - NREQ) : IW'(sum);
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) if (win == IW'(i)) sel_addr = req_addr[i*AW +: AW];
    end

    // sweep sequencing: a new frame seen during DRAIN chains straight into the next sweep
    always_comb begin
        state_nxt = (state == IDLE)  ? (new_data ? SWEEP : IDLE) :
                    (state == SWEEP) ? ((cnt == LAST_IDX) ? DRAIN : SWEEP) :
                    ((pend || new_data) ? SWEEP : IDLE);
    end

    assign grant        = !rst && state == IDLE && hit;
    assign bad          = {1'b0, sel_addr} >= POP_LIM;
    assign sweep_issue  = !rst && state == SWEEP;
    assign req_issue    = grant && !bad;
    assign gnt          = grant ? NUM_REQ'(1) << win : '0;
    assign rf_rd_rqst   = sweep_issue || req_issue;
    assign rf_read_addr = sweep_issue ? cnt : (req_issue ? sel_addr : '0);
    assign req_rsp      = !rst && tag_vld && !tag_sweep && rf_data_vld;
    assign sweep_vld    = !rst && tag_vld && tag_sweep && rf_data_vld;
    assign sweep_idx    = sweep_vld ? tag_idx : '0;
    assign sweep_done   = sweep_vld && tag_idx == LAST_IDX;
    assign rsp_vld      = req_rsp ? NUM_REQ'(1) << tag_owner :
                          ((!rst && err_vld) ? NUM_REQ'(1) << err_owner : '0);
    assign rsp_data     = (req_rsp || sweep_vld) ? rf_data : '0;

    // state, sweep counter, in-flight tag and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pend      <= 1'b0;
            last      <= LAST_REQ;
            tag_vld   <= 1'b0;
            tag_sweep <= 1'b0;
            tag_owner <= '0;
            tag_idx   <= '0;
            err_vld   <= 1'b0;
            err_owner <= '0;
            addr_err  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= (state == SWEEP && cnt != LAST_IDX) ? cnt + 1'b1 : '0;
            pend      <= (state == SWEEP) && (pend || new_data);
            last      <= grant ? win : last;
            tag_vld   <= rf_rd_rqst;
            tag_sweep <= sweep_issue;
            tag_owner <= win;
            tag_idx   <= cnt;
            err_vld   <= grant && bad;
            err_owner <= win;
            addr_err  <= addr_err || (grant && bad);
            proto_err <= proto_err || (rf_data_vld != tag_vld);
        end
    end
endmodule
